// File: rtl/alu_sequencer.sv
// alu_sequencer: command FIFO in front of the combinational integer alu.
// The FIFO head drives the alu directly. The result is captured into a
// registered valid/ready output stage. The carry flag chains carry between
// ADD/SUB commands.
module alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int SHIFT_WIDTH  = $clog2(DATA_WIDTH),
  localparam int OPCODE_WIDTH = 4,
  localparam int OCC_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_WIDTH-1:0]  cmd_shift,
  input  logic                    cmd_use_carry,
  input  logic                    flags_clear,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [SHIFT_WIDTH-1:0]  alu_shift_amt,
  output logic                    alu_carry_in,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_carry_out,
  input  logic                    alu_overflow,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_carry,
  output logic                    res_overflow,
  output logic                    carry_flag,
  output logic [OCC_WIDTH-1:0]    occupancy
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  // Opcode encoding shared with the attached alu.
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LLOG = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_RLOG = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_LROT = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_RROT = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_RAR  = 4'd9;

  typedef enum logic {RES_EMPTY, RES_FULL} res_state_t;

  logic [OPCODE_WIDTH-1:0] fifo_opcode    [DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_a         [DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_b         [DEPTH];
  logic [SHIFT_WIDTH-1:0]  fifo_shift     [DEPTH];
  logic                    fifo_use_carry [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [OCC_WIDTH-1:0] count;
  logic                 full, empty, push, fire, head_is_arith;
  res_state_t           state, state_next;

  assign full      = (count == OCC_WIDTH'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign res_valid = (state == RES_FULL);
  assign fire      = !empty && (!res_valid || res_ready);
  assign occupancy = count;
  assign head_is_arith = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);

  // Command storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_opcode[wr_ptr]    <= cmd_opcode;
      fifo_a[wr_ptr]         <= cmd_a;
      fifo_b[wr_ptr]         <= cmd_b;
      fifo_shift[wr_ptr]     <= cmd_shift;
      fifo_use_carry[wr_ptr] <= cmd_use_carry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (fire) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, fire})
        2'b10:   count <= count + OCC_WIDTH'(1);
        2'b01:   count <= count - OCC_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Present the head command to the alu; idle the operand bus when empty.
  always_comb begin
    alu_opcode    = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_shift_amt = '0;
    alu_carry_in  = 1'b0;
    if (!empty) begin
      alu_opcode    = fifo_opcode[rd_ptr];
      alu_a         = fifo_a[rd_ptr];
      alu_b         = fifo_b[rd_ptr];
      alu_shift_amt = fifo_shift[rd_ptr];
      alu_carry_in  = fifo_use_carry[rd_ptr] & carry_flag;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RES_EMPTY;
    else     state <= state_next;
  end

  // Output-stage transitions: fire always (re)fills, a lone drain empties.
  always_comb begin
    state_next = state;
    case (state)
      RES_EMPTY: if (fire) state_next = RES_FULL;
      RES_FULL:  if (res_ready && !fire) state_next = RES_EMPTY;
      default:   state_next = RES_EMPTY;
    endcase
  end

  // Result capture; holds its value across drain and back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data     <= '0;
      res_carry    <= 1'b0;
      res_overflow <= 1'b0;
    end else if (fire) begin
      res_data     <= alu_result;
      res_carry    <= alu_carry_out;
      res_overflow <= alu_overflow;
    end
  end

  // Carry flag updates on the pop edge so the next head sees it without a bypass.
  always_ff @(posedge clk) begin
    if (rst)                         carry_flag <= 1'b0;
    else if (flags_clear)            carry_flag <= 1'b0;
    else if (fire && head_is_arith)  carry_flag <= alu_carry_out;
  end

endmodule
